// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op codes, default latencies, pending-commit encoding and
// op-class helpers shared by the multiply/divide unit.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are accepted only when the
// MDU_MADD_EN macro is defined; otherwise their encodings behave as MDU_NONE.
package mul_div_unit_pkg;

    // MDU operation codes driven by the decoder into EX.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    // Default Busy durations.
    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

    // What happens to {HI,LO} when the in-flight op expires.
    typedef enum logic [1:0] {
        PEND_SKIP = 2'd0,   // leave HI/LO untouched (divide by zero)
        PEND_LOAD = 2'd1,   // {HI,LO} <= value
        PEND_ADD  = 2'd2,   // {HI,LO} <= {HI,LO} + value
        PEND_SUB  = 2'd3    // {HI,LO} <= {HI,LO} - value
    } pend_mode_e;

    typedef struct packed {
        pend_mode_e  mode;
        logic [63:0] value;
    } mdu_pend_t;

    // Ops that take the multiplier latency.
    function automatic logic op_is_mul(input mdu_op_e op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Ops that take the divider latency.
    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that start a multi-cycle operation in this build.
    function automatic logic op_starts(input mdu_op_e op);
`ifdef MDU_MADD_EN
        return op_is_mul(op) || op_is_div(op);
`else
        return (op == MDU_MULT) || (op == MDU_MULTU) || op_is_div(op);
`endif
    endfunction

    // How a successfully computed result is folded into {HI,LO} at expiry.
    function automatic pend_mode_e op_commit_mode(input mdu_op_e op);
        case (op)
            MDU_MADD, MDU_MADDU: return PEND_ADD;
            MDU_MSUB, MDU_MSUBU: return PEND_SUB;
            default:             return PEND_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/mul_div_unit_arith.sv
// mul_div_unit_arith: purely combinational 64-bit result for the op presented
// at accept time. Multiplies give the full product; divides give
// {remainder, quotient}. wr_en is low for a divide by zero so HI/LO keep
// their old values.
module mul_div_unit_arith
    import mul_div_unit_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [63:0] result,
    output logic        wr_en
);

    logic        is_signed;
    logic [63:0] ext1;
    logic [63:0] ext2;
    logic [63:0] product;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic        div_by_zero;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // One shared multiplier and one shared unsigned divider; signed ops go
    // through magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_MADD) ||
                    (op == MDU_MSUB) || (op == MDU_DIV);

        ext1    = is_signed ? {{32{operand1[31]}}, operand1} : {32'd0, operand1};
        ext2    = is_signed ? {{32{operand2[31]}}, operand2} : {32'd0, operand2};
        product = ext1 * ext2;

        dividend_mag = (is_signed && operand1[31]) ? (32'd0 - operand1) : operand1;
        divisor_mag  = (is_signed && operand2[31]) ? (32'd0 - operand2) : operand2;
        div_by_zero  = (operand2 == 32'd0);
        quot_mag     = div_by_zero ? 32'd0 : (dividend_mag / divisor_mag);
        rem_mag      = div_by_zero ? 32'd0 : (dividend_mag % divisor_mag);

        // Quotient truncates toward zero; remainder takes the dividend's sign.
        quot = (is_signed && (operand1[31] ^ operand2[31])) ? (32'd0 - quot_mag) : quot_mag;
        rem  = (is_signed && operand1[31]) ? (32'd0 - rem_mag) : rem_mag;

        result = 64'd0;
        wr_en  = 1'b0;
        if (op_is_mul(op)) begin
            result = product;
            wr_en  = 1'b1;
        end else if (op_is_div(op)) begin
            result = {rem, quot};
            wr_en  = !div_by_zero;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// The result is computed at accept and held as a pending commit; a down
// counter models the multi-cycle latency and Busy is simply (counter != 0).
// HI/LO are written on the edge where the counter goes 1 -> 0.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input  logic        MDU_i_clk,
    input  logic        MDU_i_reset_n,
    input  logic [31:0] MDU_i_Operand1,
    input  logic [31:0] MDU_i_Operand2,
    input  logic [3:0]  MDU_i_Operation,
    input  logic        MDU_i_Start,
    output logic        MDU_o_Busy,
    output logic [31:0] MDU_o_HI,
    output logic [31:0] MDU_o_LO,
    output logic [31:0] MDU_o_Result
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t MUL_LOAD = cnt_t'(MUL_CYCLES);
    localparam cnt_t DIV_LOAD = cnt_t'(DIV_CYCLES);

    mdu_op_e     op;
    logic        busy;
    logic        accept;
    logic        expire;
    logic [63:0] arith_result;
    logic        arith_wr_en;
    logic [63:0] hilo_cur;
    logic [63:0] hilo_next;

    cnt_t        cnt_q,  cnt_d;
    logic [31:0] hi_q,   hi_d;
    logic [31:0] lo_q,   lo_d;
    mdu_pend_t   pend_q, pend_d;

    assign op       = mdu_op_e'(MDU_i_Operation);
    assign busy     = (cnt_q != '0);
    assign accept   = MDU_i_Start && !busy && op_starts(op);
    assign expire   = (cnt_q == cnt_t'(1));
    assign hilo_cur = {hi_q, lo_q};

    mul_div_unit_arith u_arith (
        .op       (op),
        .operand1 (MDU_i_Operand1),
        .operand2 (MDU_i_Operand2),
        .result   (arith_result),
        .wr_en    (arith_wr_en)
    );

    // Fold the pending value into the HI/LO contents present at commit time.
    always_comb begin
        hilo_next = hilo_cur;
        case (pend_q.mode)
            PEND_LOAD: hilo_next = pend_q.value;
            PEND_ADD:  hilo_next = hilo_cur + pend_q.value;
            PEND_SUB:  hilo_next = hilo_cur - pend_q.value;
            default:   hilo_next = hilo_cur;
        endcase
    end

    // Next-state: count down while busy and commit on expiry; when idle,
    // accept a new op or perform a single-cycle MTHI/MTLO.
    always_comb begin
        // NOTE: every *_d starts as its *_q so no path leaves a signal unassigned and infers a latch.
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;

        if (busy) begin
            cnt_d = cnt_q - cnt_t'(1);
            if (expire) begin
                {hi_d, lo_d} = hilo_next;
            end
        end else if (accept) begin
            cnt_d        = op_is_mul(op) ? MUL_LOAD : DIV_LOAD;
            pend_d.value = arith_result;
            pend_d.mode  = arith_wr_en ? op_commit_mode(op) : PEND_SKIP;
        end else if (op == MDU_MTHI) begin
            hi_d = MDU_i_Operand1;
        end else if (op == MDU_MTLO) begin
            lo_d = MDU_i_Operand1;
        end
    end

    // State registers.
    always_ff @(posedge MDU_i_clk or negedge MDU_i_reset_n) begin
        // NOTE: the pending result is reset along with the counter so an op aborted by reset can never commit later.
        if (!MDU_i_reset_n) begin
            cnt_q  <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            pend_q <= '{mode: PEND_SKIP, value: 64'd0};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    // MFHI/MFLO read mux into the EX result; zero for every other op.
    always_comb begin
        MDU_o_Result = 32'd0;
        case (op)
            MDU_MFHI: MDU_o_Result = hi_q;
            MDU_MFLO: MDU_o_Result = lo_q;
            default:  MDU_o_Result = 32'd0;
        endcase
    end

    assign MDU_o_Busy = busy;
    assign MDU_o_HI   = hi_q;
    assign MDU_o_LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit. Each accepted
// multi-cycle op pushes its expected Busy length and HI/LO into a queue; a
// monitor pops on every Busy falling edge. Expected values come from a plain
// arithmetic reference model of HI/LO.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op1   = 32'd0;
    logic [31:0] op2   = 32'd0;
    logic [3:0]  op    = 4'd0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clk = ~clk;

    mul_div_unit #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .MDU_i_clk       (clk),
        .MDU_i_reset_n   (rst_n),
        .MDU_i_Operand1  (op1),
        .MDU_i_Operand2  (op2),
        .MDU_i_Operation (op),
        .MDU_i_Start     (start),
        .MDU_o_Busy      (busy),
        .MDU_o_HI        (hi),
        .MDU_o_LO        (lo),
        .MDU_o_Result    (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: architectural effect of one issued op on HI/LO.
    task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ps;
        logic [63:0] pu;
        logic [63:0] acc;
        exp_t        e;
        bit          multi;
        multi    = 1'b0;
        e.cycles = MUL_N;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'd0, a} * {32'd0, b};
        acc = {model_hi, model_lo};
        case (o)
            MDU_MULT:  begin multi = 1'b1; acc = ps; end
            MDU_MULTU: begin multi = 1'b1; acc = pu; end
            MDU_DIV: begin
                multi = 1'b1; e.cycles = DIV_N;
                if (b != 32'd0) acc = {32'(sa % sb), 32'(sa / sb)};
            end
            MDU_DIVU: begin
                multi = 1'b1; e.cycles = DIV_N;
                if (b != 32'd0) acc = {a % b, a / b};
            end
            MDU_MTHI: acc[63:32] = a;
            MDU_MTLO: acc[31:0]  = a;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin multi = 1'b1; acc = acc + ps; end
            MDU_MADDU: begin multi = 1'b1; acc = acc + pu; end
            MDU_MSUB:  begin multi = 1'b1; acc = acc - ps; end
            MDU_MSUBU: begin multi = 1'b1; acc = acc - pu; end
`endif
            default: ;
        endcase
        {model_hi, model_lo} = acc;
        if (multi) begin
            e.hi = model_hi;
            e.lo = model_lo;
            e.op = o;
            sb_q.push_back(e);
        end
    endtask

    // Present one op for a single clock; checks the combinational result mux
    // and optionally advances the reference model.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit apply);
        @(negedge clk);
        op = o; op1 = a; op2 = b; start = s;
        #1;
        if (o == MDU_MFHI)      check("mfhi_result", result, model_hi);
        else if (o == MDU_MFLO) check("mflo_result", result, model_lo);
        else                    check("result_zero", result, 32'd0);
        @(negedge clk);
        op = MDU_NONE; start = 1'b0;
        if (apply) model_apply(o, a, b);
    endtask

    // Wait (bounded) for Busy to drop, then one more cycle for the monitor.
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    // Monitor: measure each Busy run and compare against the scoreboard.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (busy) begin
                run++;
            end else if (run != 0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_busy_run", 32'(run), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("busy_len_op%0d", e.op), 32'(run), 32'(e.cycles));
                    check($sformatf("hi_op%0d", e.op), hi, e.hi);
                    check($sformatf("lo_op%0d", e.op), lo, e.lo);
                end
                run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state.
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Signed and unsigned multiply.
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
        wait_idle();
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
        wait_idle();
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // Signed and unsigned divide.
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        wait_idle();
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(MDU_DIVU, 32'd7, 32'd2, 1'b1, 1'b1);
        wait_idle();
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // MTHI/MTLO, divide by zero keeps HI/LO, MTHI ignored while busy.
        issue(MDU_MTHI, 32'h11, 32'd0, 1'b0, 1'b1);
        issue(MDU_MTLO, 32'h22, 32'd0, 1'b0, 1'b1);
        issue(MDU_DIV, 32'd5, 32'd0, 1'b1, 1'b1);
        issue(MDU_MTHI, 32'h99, 32'd0, 1'b0, 1'b0);
        wait_idle();
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);
        issue(MDU_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(MDU_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);

        // Second Start with changed operands while busy is ignored.
        issue(MDU_MULT, 32'd3, 32'd4, 1'b1, 1'b1);
        issue(MDU_MULT, 32'd5, 32'd6, 1'b1, 1'b0);
        wait_idle();
        check("overlap_lo", lo, 32'd12);
        check("overlap_hi", hi, 32'd0);

        // Most negative / -1.
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_idle();
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);

        // Start with a non multi-cycle op never raises Busy.
        issue(MDU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0);
        check("start_mfhi_busy", {31'd0, busy}, 32'd0);
        issue(MDU_NONE, 32'd9, 32'd9, 1'b1, 1'b0);
        check("start_none_busy", {31'd0, busy}, 32'd0);

        // Accumulate ops.
        issue(MDU_MTHI, 32'd0, 32'd0, 1'b0, 1'b1);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        issue(MDU_MADDU, 32'd1, 32'd1, 1'b1, 1'b1);
`ifdef MDU_MADD_EN
        wait_idle();
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        wait_idle();
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset aborts an in-flight divide.
        issue(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_later_busy", {31'd0, busy}, 32'd0);
        check("abort_later_hi", hi, 32'd0);
        check("abort_later_lo", lo, 32'd0);

        // Randomised mix against the reference model.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 10)) - 32'd5;
            case ($urandom_range(0, 8))
                0: ro = MDU_MULT;
                1: ro = MDU_MULTU;
                2: ro = MDU_DIV;
                3: ro = MDU_DIVU;
                4: ro = MDU_MTHI;
                5: ro = MDU_MTLO;
                6: ro = MDU_MFHI;
                7: ro = MDU_MFLO;
                default: ro = 4'($urandom_range(9, 12));
            endcase
            issue(ro, ra, rb, 1'b1, 1'b1);
            wait_idle();
        end
        issue(MDU_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        issue(MDU_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);

        wait_idle();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- EX-stage neighbour of the ALU in the P5/P6 pipeline: consumes the same forwarded EX operands and handles MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Owns the HI/LO architectural registers and models multi-cycle latency with a Busy flag.
- The hazard unit stalls ID while Start or Busy is high.
- MFHI/MFLO read data is muxed into the EX result alongside ALU_o_Result.

Parameters:
- MUL_CYCLES, 5, Busy duration for MULT/MULTU (≥1)
- DIV_CYCLES, 10, Busy duration for DIV/DIVU (≥1)

Ports:
- MDU_i_clk  input  1  clock
- MDU_i_reset_n  input  1  asynchronous active-low reset
- MDU_i_Operand1  input  32  rs value (dividend / multiplicand / MTxx source)
- MDU_i_Operand2  input  32  rt value (divisor / multiplier)
- MDU_i_Operation  input  4  MDU op code (MDU_NONE when idle)
- MDU_i_Start  input  1  EX holds a MULT/MULTU/DIV/DIVU this cycle
- MDU_o_Busy  output  1  multi-cycle op in progress
- MDU_o_HI  output  32  HI register
- MDU_o_LO  output  32  LO register
- MDU_o_Result  output  32  MFHI→HI, MFLO→LO, else 0; combinational

Behaviour:
- Reset (async, low): HI=0, LO=0, counter=0, Busy=0, pending result cleared. An op in flight is aborted and never commits.
- Start acceptance: accepted on a rising edge when Start=1, Busy=0, and Operation ∈ {MULT, MULTU, DIV, DIVU}.
  - Operands latched; counter loaded with MUL_CYCLES or DIV_CYCLES.
  - Start while Busy=1 is ignored; hazard unit guarantees it does not occur.
  - Start with any other op is ignored.
- Busy = (counter != 0), registered. If accepted at edge k, Busy is high for exactly N cycles after edge k.
  - Counter decrements each edge.
  - On the edge where the counter goes 1→0, HI/LO are written. New values are visible in the first cycle with Busy=0.
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned LO = quotient, HI = remainder.
- Divide by zero (DIV/DIVU, Operand2=0): Busy still runs DIV_CYCLES; HI/LO left unchanged.
- Result computation may be combinational at accept, stored as pending; the counter only gates visibility.
- MTHI/MTLO: when Busy=0, HI or LO ← Operand1 on the edge; single cycle, no Busy. Ignored while Busy=1.
- MFHI/MFLO: MDU_o_Result reflects the current register value. While Busy=1 it returns the old value; the stall prevents this case.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds ops MADD, MADDU, MSUB, MSUBU (MUL_CYCLES latency). {HI,LO} ← {HI,LO} ± product, signed or unsigned per op, mod 2^64, using the HI/LO value at commit.
- Undefined: those encodings are treated as MDU_NONE (ignored; no Busy).

Decomposition:
- Shared macro.v gets:
  - MDU op codes: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO, and under MDU_MADD_EN: MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU.
  - Default cycle counts.
- No sub-module: the single always-block counter plus datapath is natural. Optionally split out mdu_arith (pure combinational 64-bit result calc) to keep the sequential part clean.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- HI=0x11, LO=0x22 via MTHI/MTLO; then DIV x/0 → Busy 10 cycles; HI=0x11, LO=0x22 unchanged; MFLO Result=0x22.
- MULT 3×4 accepted, operands changed and second Start asserted at cycle 2 → second ignored; LO=12 after 5 cycles.
- DIV started; reset_n pulled low at cycle 4 → Busy=0, HI=LO=0 immediately (async); no later commit.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF; MADDU 1×1 → HI=1, LO=0. Without macro → no Busy, HI/LO unchanged.
